issue_arbiter: RTL and testbench
================================

# issue_arbiter

Round-robin arbiter that shares one execution-unit input among `PORTS` issue buffers. Each requester presents one ready-to-issue instruction with a valid/ready handshake. The arbiter grants at most one requester per cycle and captures the winner in a single registered output stage, tagged with its source index. It sits between the per-class issue buffers and a shared functional unit (e.g. the ALU).

## Interface

Parameters:
- `DATA_WIDTH`, default 47: instruction word width, identical to the issue buffer entry width.
- `PORTS`, default 3: number of requesting issue buffers; legal range 2..8.
- `SRC_W`, default `$clog2(PORTS)`: width of the source tag.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous pipeline flush (branch mispredict).
- `req_data`  in  `PORTS*DATA_WIDTH`: packed instructions; port i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_valid`  in  `PORTS`: per-port instruction valid.
- `req_ready`  out  `PORTS`: per-port grant/accept, one-hot or zero.
- `dout`  out  `DATA_WIDTH`: registered granted instruction.
- `dout_src`  out  `SRC_W`: index of the port `dout` came from.
- `dout_valid`  out  1: output register holds a valid instruction.
- `dout_ready`  in  1: functional unit accepts `dout` this cycle.

## Operation

State:
- Output register: `dout`, `dout_src`, `dout_valid`.
- Round-robin pointer `last` (`SRC_W` bits), holding the index of the most recent grant.

Acceptance:
- `accept = (!dout_valid || dout_ready) && !flush`.

Grant selection:
- The search order is `last+1, last+2, …` modulo `PORTS`, wrapping from `PORTS-1` to 0. Index arithmetic is done in `SRC_W+1` bits before the modulo.
- The first valid port in that order wins.
- `req_ready[i] = accept && winner==i`. At most one bit is set. All bits are 0 if no port is valid or `accept=0`.
- A handshake on port i occurs when `req_valid[i] && req_ready[i]`. On that edge: `dout <= req_data[i]`, `dout_src <= i`, `dout_valid <= 1`, `last <= i`.
- If `dout_valid && dout_ready` and there is no new handshake, `dout_valid <= 0`. `dout` and `dout_src` hold their stale values.

Flush:
- `flush=1` forces `dout_valid <= 0` and drives all `req_ready` bits to 0. `last` is unchanged.
- Flush overrides `dout_ready` and any pending request in the same cycle.

Req/ready dependency rule:
- `req_ready` depends combinationally on `req_valid`.
- Requesters must not derive `req_valid` from `req_ready`. The issue buffer cap already satisfies this.
- `dout_ready` may depend on `dout_valid`, but not on `req_*`.

Reset values:
- `dout_valid=0`, `dout=0`, `dout_src=0`, `last=PORTS-1`, so port 0 has first priority after reset.
- Reset mid-transfer discards the held instruction. No handshake completes in a cycle where `rst` is high.

## Timing

- Latency: a request handshake in cycle N produces `dout_valid=1` with that data in cycle N+1.
- Throughput: one instruction per cycle while `dout_ready` stays high. A drain and a refill in the same cycle keep `dout_valid` continuously high.
- Backpressure:
  - `dout_valid && !dout_ready` gives `accept=0`: `req_ready` is all-zero and `dout`/`dout_src` are stable.
  - `dout` must not change while `dout_valid && !dout_ready`.
- Fairness: with all ports continuously valid and `dout_ready=1`, grants cycle 0,1,…,`PORTS-1`,0. Any continuously-valid port waits at most `PORTS-1` grants.
- Simultaneous drain and new handshake: the new instruction replaces the old one on the same edge; `dout_valid` stays 1.
- Register empty with no requests: output is idle and `last` holds.
- Critical path: the rotate-and-priority-encode over `PORTS` ports plus the `DATA_WIDTH` mux. No internal path from `dout_ready` to `dout`.

## Configuration

- `ISSUE_ARB_FIXED_PRIO_EN`:
  - Defined: round-robin is replaced by fixed priority. The lowest-index valid port always wins, `last` is not instantiated, and fairness is not guaranteed.
  - Undefined (default): round-robin behaviour as above.
- All other behaviour, including reset, flush, handshake and latency, is identical in both builds.

## Test plan

All scenarios use `PORTS=3` and `DATA_WIDTH=47`.

- **Reset/first grant:** after reset, `req_valid=3'b111` with data `0x11/0x22/0x33` and `dout_ready=1`.
  - Grants are port 0, 1, 2, 0 on consecutive cycles.
  - `dout` is `0x11, 0x22, 0x33, 0x11` one cycle later each, with `dout_src` 0,1,2,0.
- **Backpressure:** `dout_ready=0` for 4 cycles with `req_valid=3'b010`.
  - First cycle: port 1 is granted.
  - Following cycles: `req_ready=0` and `dout`/`dout_valid=1` stay stable.
  - Raise `dout_ready`: port 1 is granted again on that same cycle.
- **Sparse wrap:** `last=2`, `req_valid=3'b100`.
  - Port 2 is granted, since the search 0,1,2 wraps to it.
  - Then `req_valid=3'b101` grants port 0.
- **Flush collision:** `dout_valid=1`, `req_valid=3'b001` and `flush=1` in the same cycle.
  - Next cycle: `dout_valid=0`, and port 0 is not consumed.
  - The cycle after: port 0 is granted.
- **Async reset mid-stream:** assert `rst` between clock edges while `dout_valid=1`.
  - `dout_valid` drops immediately, with no edge required.
  - After release, port 0 has priority.
- **Fixed-priority build:** with `ISSUE_ARB_FIXED_PRIO_EN` defined, repeat the first scenario.
  - Port 0 is granted every cycle; ports 1 and 2 see `req_ready=0`.

Source files
------------

// File: rtl/issue_arbiter.sv
// issue_arbiter: round-robin arbiter that funnels PORTS issue buffers into one
// registered output stage feeding a shared functional unit.
// The winning instruction is captured together with its source port index.
// Build option ISSUE_ARB_FIXED_PRIO_EN: when defined, round-robin is replaced
// by fixed lowest-index priority, and the round-robin pointer is not built.
module issue_arbiter #(
    parameter int DATA_WIDTH = 47,
    parameter int PORTS      = 3,
    parameter int SRC_W      = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [PORTS*DATA_WIDTH-1:0] req_data,
    input  logic [PORTS-1:0]            req_valid,
    output logic [PORTS-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic [SRC_W-1:0]            dout_src,
    output logic                        dout_valid,
    input  logic                        dout_ready
);

    localparam int               SUM_W     = SRC_W + 1;
    localparam logic [SUM_W-1:0] PORTS_EXT = SUM_W'(PORTS);

    logic                  accept_s;
    logic                  found_s;
    logic                  hit_s;
    logic [SRC_W-1:0]      winner_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [DATA_WIDTH-1:0] dout_r;
    logic [SRC_W-1:0]      dout_src_r;
    logic                  dout_valid_r;

    // The output stage can take a new instruction when empty or draining,
    // unless a flush is in progress.
    assign accept_s = (!dout_valid_r || dout_ready) && !flush;
    assign hit_s    = accept_s && found_s;

`ifdef ISSUE_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest valid index wins last.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            winner_s = req_valid[k] ? SRC_W'(k) : winner_s;
            found_s  = found_s | req_valid[k];
        end
    end
`else
    logic [SRC_W-1:0] last_r;
    logic [SUM_W-1:0] idx_s;

    // Round-robin: search last+1 .. last+PORTS (mod PORTS); scanning the
    // offsets downward lets the nearest valid port overwrite farther ones.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        idx_s    = '0;
        for (int k = PORTS; k >= 1; k--) begin
            idx_s    = {1'b0, last_r} + SUM_W'(k);
            idx_s    = (idx_s >= PORTS_EXT) ? (idx_s - PORTS_EXT) : idx_s;
            winner_s = req_valid[idx_s[SRC_W-1:0]] ? idx_s[SRC_W-1:0] : winner_s;
            found_s  = found_s | req_valid[idx_s[SRC_W-1:0]];
        end
    end

    // Pointer remembers the most recent grant; reset makes port 0 next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= SRC_W'(PORTS - 1);
        end else if (hit_s) begin
            last_r <= winner_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    // Data mux selecting the winning port's instruction word.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < PORTS; i++) begin
            sel_data_s = (winner_s == SRC_W'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                 : sel_data_s;
        end
    end

    // One-hot accept back to the issue buffers; all-zero when nothing is taken.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < PORTS; i++) begin
            req_ready[i] = hit_s && (winner_s == SRC_W'(i));
        end
    end

    // Output stage: flush drops the held instruction, a grant loads a new one,
    // a drain without refill clears valid while data and tag stay put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r       <= '0;
            dout_src_r   <= '0;
            dout_valid_r <= 1'b0;
        end else if (flush) begin
            dout_valid_r <= 1'b0;
        end else if (hit_s) begin
            dout_r       <= sel_data_s;
            dout_src_r   <= winner_s;
            dout_valid_r <= 1'b1;
        end else if (dout_ready) begin
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= dout_valid_r;
        end
    end

    assign dout       = dout_r;
    assign dout_src   = dout_src_r;
    assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_issue_arbiter.sv
// Self-checking bench for issue_arbiter (PORTS=3, DATA_WIDTH=47): directed
// scenarios with literal expectations plus randomized traffic, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_issue_arbiter;

    localparam int DW = 47;
    localparam int P  = 3;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [P*DW-1:0] req_data;
    logic [P-1:0]    req_valid;
    logic [P-1:0]    req_ready;
    logic [DW-1:0]   dout;
    logic [SW-1:0]   dout_src;
    logic            dout_valid;
    logic            dout_ready;

    int tests = 0;
    int fails = 0;

    // model state: what the output register holds and who was granted last
    bit            m_valid;
    logic [DW-1:0] m_dout;
    int            m_src;
    int            m_last;
    int            m_win;

    issue_arbiter #(.DATA_WIDTH(DW), .PORTS(P)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .dout(dout), .dout_src(dout_src), .dout_valid(dout_valid),
        .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which port the rules say must be granted this cycle, -1 for none.
    function automatic int model_winner();
        int idx;
        if (!((!m_valid || dout_ready) && !flush)) return -1;
`ifdef ISSUE_ARB_FIXED_PRIO_EN
        for (int k = 0; k < P; k++) if (req_valid[k]) return k;
`else
        for (int k = 1; k <= P; k++) begin
            idx = (m_last + k) % P;
            if (req_valid[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_dout  = '0;
        m_src   = 0;
        m_last  = P - 1;
    endtask

    // Apply inputs (called just after a falling edge) and compare the DUT.
    task automatic drive(input logic [P-1:0] v, input logic rdy, input logic fl);
        req_valid  = v;
        dout_ready = rdy;
        flush      = fl;
        #1;
        m_win = model_winner();
        check("req_ready", 64'(req_ready), (m_win < 0) ? 64'd0 : (64'd1 << m_win));
        check("dout_valid", 64'(dout_valid), 64'(m_valid));
        check("dout", 64'(dout), 64'(m_dout));
        check("dout_src", 64'(dout_src), 64'(m_src));
    endtask

    // Take the rising edge, advance the model, return to the falling edge.
    task automatic advance();
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
        end else if (m_win >= 0) begin
            m_dout  = req_data[m_win*DW +: DW];
            m_src   = m_win;
            m_valid = 1'b1;
            m_last  = m_win;
        end else if (dout_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    logic [P-1:0]  exp_rdy [4];
    logic [DW-1:0] exp_dat [4];
    logic [63:0]   rnd;

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = '0;
        dout_ready = 1'b0;
        req_data   = {47'h33, 47'h22, 47'h11};
        model_reset();
        #1;
        check("reset_valid", 64'(dout_valid), 64'd0);
        check("reset_dout", 64'(dout), 64'd0);
        check("reset_src", 64'(dout_src), 64'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ISSUE_ARB_FIXED_PRIO_EN
        exp_rdy = '{3'b001, 3'b001, 3'b001, 3'b001};
        exp_dat = '{47'h11, 47'h11, 47'h11, 47'h11};
`else
        exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_dat = '{47'h11, 47'h22, 47'h33, 47'h11};
`endif
        // first grants after reset
        for (int i = 0; i < 4; i++) begin
            drive(3'b111, 1'b1, 1'b0);
            check("s1_grant", 64'(req_ready), 64'(exp_rdy[i]));
            advance();
            check("s1_dout", 64'(dout), 64'(exp_dat[i]));
            check("s1_valid", 64'(dout_valid), 64'd1);
        end

        // backpressure: drain, then grant port 1 and stall four cycles
        drive(3'b000, 1'b1, 1'b0);
        advance();
        check("bp_empty", 64'(dout_valid), 64'd0);
        drive(3'b010, 1'b0, 1'b0);
        check("bp_first", 64'(req_ready), 64'b010);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(3'b010, 1'b0, 1'b0);
            check("bp_stall_rdy", 64'(req_ready), 64'd0);
            advance();
            check("bp_stall_dout", 64'(dout), 64'h22);
            check("bp_stall_valid", 64'(dout_valid), 64'd1);
        end
        drive(3'b010, 1'b1, 1'b0);
        check("bp_release", 64'(req_ready), 64'b010);
        advance();

        // sparse wrap: port 2 alone, twice, then ports 0 and 2
        drive(3'b100, 1'b1, 1'b0);
        check("wrap_a", 64'(req_ready), 64'b100);
        advance();
        drive(3'b100, 1'b1, 1'b0);
        check("wrap_b", 64'(req_ready), 64'b100);
        advance();
        drive(3'b101, 1'b1, 1'b0);
        check("wrap_c", 64'(req_ready), 64'b001);
        advance();

        // flush collides with a pending request
        drive(3'b001, 1'b1, 1'b1);
        check("flush_rdy", 64'(req_ready), 64'd0);
        advance();
        check("flush_valid", 64'(dout_valid), 64'd0);
        drive(3'b001, 1'b1, 1'b0);
        check("flush_after", 64'(req_ready), 64'b001);
        advance();
        check("flush_refill", 64'(dout_valid), 64'd1);

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("areset_valid", 64'(dout_valid), 64'd0);
        check("areset_dout", 64'(dout), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(3'b111, 1'b1, 1'b0);
        check("areset_prio", 64'(req_ready), 64'b001);
        advance();

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < P; i++) begin
                rnd = {$urandom, $urandom};
                req_data[i*DW +: DW] = rnd[DW-1:0];
            end
            drive(P'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
